// File: rtl/branch_cmp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : branch_cmp_pkg
//  Description : Shared funct3 codes, FSM state type and branch decode helpers
//  Revision    : 1.0 - initial release
// ============================================================================
package branch_cmp_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    // Only the 11x codes compare unsigned; everything else, illegal codes included, is signed.
    function automatic logic is_signed_op(input logic [2:0] f3);
        return !(f3[2] && f3[1]);
    endfunction

    function automatic logic is_illegal(input logic [2:0] f3);
        return (f3[2:1] == 2'b01);
    endfunction

    function automatic logic branch_taken(input logic [2:0] f3, input logic lt, input logic eq);
        logic t;
        case (f3)
            F3_BEQ:           t = eq;
            F3_BNE:           t = !eq;
            F3_BLT, F3_BLTU:  t = lt;
            F3_BGE, F3_BGEU:  t = !lt;
            default:          t = 1'b0;
        endcase
        return t;
    endfunction

endpackage
`default_nettype wire

// File: rtl/chunk_compare.sv
`default_nettype none
// ============================================================================
//  Module      : chunk_compare
//  Description : CHUNK-wide unsigned slice compare with optional MSB flip
//                so a top slice can be ordered as signed
//  Revision    : 1.0 - initial release
// ============================================================================
module chunk_compare #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             invert_msb,
    output logic             lt,
    output logic             eq
);

    logic [CHUNK-1:0] w_mask;
    logic [CHUNK-1:0] w_a;
    logic [CHUNK-1:0] w_b;

    assign w_mask = {invert_msb, {(CHUNK-1){1'b0}}};
    assign w_a    = a ^ w_mask;
    assign w_b    = b ^ w_mask;
    assign lt     = (w_a < w_b);
    assign eq     = (a == b);

endmodule
`default_nettype wire

// File: rtl/branch_compare_unit.sv
`default_nettype none
// ============================================================================
//  Module      : branch_compare_unit
//  Description : MSB-first multi-cycle branch comparator with early exit at
//                the first differing slice; valid/ready on both sides
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_compare_unit
    import branch_cmp_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int CHUNK = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic [2:0]      funct3_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic            taken_o,
    output logic            lt_o,
    output logic            eq_o,
    output logic            illegal_o
);

    localparam int NSLICE = XLEN / CHUNK;
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDX_W-1:0] C_TOP_IDX = IDX_W'(NSLICE - 1);
    localparam logic [IDX_W-1:0] C_ONE     = IDX_W'(1);

    generate
        if ((XLEN % CHUNK) != 0 || CHUNK < 2) begin : g_param_check
            $error("branch_compare_unit: XLEN must be a multiple of CHUNK and CHUNK >= 2");
        end
    endgenerate

    state_t            r_state;
    logic [IDX_W-1:0]  r_idx;
    logic [XLEN-1:0]   r_rs1;
    logic [XLEN-1:0]   r_rs2;
    logic [2:0]        r_funct3;

    logic [CHUNK-1:0]  w_slice_a [NSLICE];
    logic [CHUNK-1:0]  w_slice_b [NSLICE];
    logic [CHUNK-1:0]  w_sel_a;
    logic [CHUNK-1:0]  w_sel_b;
    logic              w_invert;
    logic              w_lt;
    logic              w_eq;

    genvar gi;
    generate
        for (gi = 0; gi < NSLICE; gi++) begin : g_slice
            assign w_slice_a[gi] = r_rs1[gi*CHUNK +: CHUNK];
            assign w_slice_b[gi] = r_rs2[gi*CHUNK +: CHUNK];
        end
    endgenerate

    assign w_sel_a  = w_slice_a[r_idx];
    assign w_sel_b  = w_slice_b[r_idx];
    assign w_invert = is_signed_op(r_funct3) && (r_idx == C_TOP_IDX);

    chunk_compare #(
        .CHUNK      (CHUNK)
    ) u_chunk_compare (
        .a          (w_sel_a),
        .b          (w_sel_b),
        .invert_msb (w_invert),
        .lt         (w_lt),
        .eq         (w_eq)
    );

    assign ready_o = (r_state == IDLE);
    assign valid_o = (r_state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_idx     <= '0;
            r_rs1     <= '0;
            r_rs2     <= '0;
            r_funct3  <= '0;
            taken_o   <= 1'b0;
            lt_o      <= 1'b0;
            eq_o      <= 1'b0;
            illegal_o <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (valid_i) begin
                        r_rs1    <= rs1_i;
                        r_rs2    <= rs2_i;
                        r_funct3 <= funct3_i;
                        r_idx    <= C_TOP_IDX;
                        r_state  <= SCAN;
                    end
                end
                SCAN: begin
                    if (!w_eq) begin
                        lt_o      <= w_lt;
                        eq_o      <= 1'b0;
                        taken_o   <= branch_taken(r_funct3, w_lt, 1'b0);
                        illegal_o <= is_illegal(r_funct3);
                        r_state   <= DONE;
                    end else if (r_idx == '0) begin
                        lt_o      <= 1'b0;
                        eq_o      <= 1'b1;
                        taken_o   <= branch_taken(r_funct3, 1'b0, 1'b1);
                        illegal_o <= is_illegal(r_funct3);
                        r_state   <= DONE;
                    end else begin
                        r_idx <= r_idx - C_ONE;
                    end
                end
                DONE: begin
                    // Returning to IDLE first keeps a new accept off the handshake edge.
                    if (ready_i) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
